// File: rtl/rv_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// rv_boot_pkg
//   Shared types and constants for the RISC-V boot loader slice.
//   - boot_state_e   : loader FSM states
//   - HDR_BYTES      : bytes in the little-endian word-count header
//   - BYTES_PER_WORD : payload bytes per IMEM word (little-endian)
//   - CSUM_W         : width of the modular running checksum
//   - accepts_bytes(): states in which the byte stream is consumed
// ---------------------------------------------------------------------------
package rv_boot_pkg;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } boot_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;

    function automatic logic accepts_bytes(input boot_state_e s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/rv_boot_loader_byte_to_word.sv
// ---------------------------------------------------------------------------
// rv_byte_to_word
//   Little-endian byte-to-word assembler. The first byte of a word lands in
//   bits [7:0]. word_o and word_valid_o are combinational so the word is
//   available in the same cycle its last byte is pushed.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     clear_i       : synchronous restart (index and partial word cleared)
//     push_i        : a byte is accepted this cycle
//     byte_i        : the accepted byte
//     word_o        : assembled word (valid when word_valid_o is high)
//     word_valid_o  : one-cycle pulse on the final byte of a word
// ---------------------------------------------------------------------------
module rv_byte_to_word
    import rv_boot_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          word_valid_o
);

    localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam int                BUF_W    = 8 * (BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx_q;
    logic [BUF_W-1:0] byte_buf_q;

    // Earlier bytes are shifted down so the buffer is already in final order.
    assign word_o       = {byte_i, byte_buf_q};
    assign word_valid_o = push_i && (idx_q == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            byte_buf_q <= '0;
        end else if (clear_i) begin
            idx_q      <= '0;
            byte_buf_q <= '0;
        end else if (push_i) begin
            // Index is exactly wide enough to wrap back to 0 after the last byte.
            idx_q      <= idx_q + 1'b1;
            byte_buf_q <= {byte_i, byte_buf_q[BUF_W-1:8]};
        end
    end

endmodule

// File: rtl/rv_boot_loader.sv
// ---------------------------------------------------------------------------
// rv_boot_loader
//   Loads a program image from a valid/ready byte stream into instruction
//   memory, verifies an 8-bit additive checksum, then releases the core from
//   reset. Frame: N[7:0], N[15:8], 4*N little-endian payload bytes, checksum.
//   The checksum is the modular sum of header and payload bytes.
//
//   Build option: define BOOT_RELOAD_EN to add the `reload` input, which
//   restarts the loader from RUN or ERROR without a full reset.
//
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     rx_valid, rx_data   : incoming byte stream
//     rx_ready            : loader can accept a byte (registered)
//     imem_we             : one-cycle IMEM write strobe per word
//     imem_addr           : IMEM word address (holds between strobes)
//     imem_wdata          : IMEM write data (holds between strobes)
//     core_reset          : active-high reset to the core
//     done                : image loaded and verified, core running
//     err                 : image rejected (sticky)
//     reload              : restart request (BOOT_RELOAD_EN only)
// ---------------------------------------------------------------------------
module rv_boot_loader
    import rv_boot_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
`ifdef BOOT_RELOAD_EN
    ,
    input  logic              reload
`endif
);

    localparam int               LEN_W = 8 * HDR_BYTES;
    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

    boot_state_e        state_q, state_d;
    logic [LEN_W-1:0]   n_q;
    logic [LEN_W-1:0]   word_idx_q;
    logic [CSUM_W-1:0]  csum_q;
    logic               rx_ready_q;
    logic               imem_we_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [31:0]        imem_wdata_q;
    logic               core_reset_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               reload_req;
    logic               restart;
    logic               word_valid;
    logic [31:0]        word;
    logic [LEN_W-1:0]   n_full;

`ifdef BOOT_RELOAD_EN
    assign reload_req = reload;
`else
    assign reload_req = 1'b0;
`endif

    assign accept  = rx_valid && rx_ready_q;
    assign restart = reload_req && ((state_q == ST_RUN) || (state_q == ST_ERROR));
    // Full word count as it becomes known on the second header byte.
    assign n_full  = {rx_data, n_q[7:0]};

    rv_byte_to_word u_byte_to_word (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (restart),
        .push_i       (accept && (state_q == ST_DATA)),
        .byte_i       (rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // NOTE: state_d is assigned first on every path so the combinational
    // block can never hold a previous value and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR0: if (accept) state_d = ST_HDR1;
            ST_HDR1: begin
                if (accept) begin
                    if (n_full > MAX_N)      state_d = ST_ERROR;
                    else if (n_full == '0)   state_d = ST_CSUM;
                    else                     state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid && (word_idx_q == n_q - LEN_W'(1))) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
            end
            ST_RUN, ST_ERROR: if (restart) state_d = ST_HDR0;
            default: state_d = ST_HDR0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HDR0;
            n_q          <= '0;
            word_idx_q   <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered from the next state so it lines up with state_q.
            rx_ready_q <= accepts_bytes(state_d);
            imem_we_q  <= 1'b0;

            if (accept && (state_q != ST_CSUM)) csum_q <= csum_q + rx_data;

            unique case (state_q)
                ST_HDR0: if (accept) n_q[7:0] <= rx_data;
                ST_HDR1: begin
                    if (accept) begin
                        n_q <= n_full;
                        if (n_full > MAX_N) err_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_idx_q[ADDR_W-1:0];
                        imem_wdata_q <= word;
                        word_idx_q   <= word_idx_q + LEN_W'(1);
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            core_reset_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_ERROR: begin
                    // IMEM address/data keep their last values across a restart.
                    if (restart) begin
                        core_reset_q <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        n_q          <= '0;
                        word_idx_q   <= '0;
                        csum_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rv_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_rv_boot_loader
//   Self-checking bench for rv_boot_loader: a table of known frames plus
//   randomized frames scored by a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_rv_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              err;
`ifdef BOOT_RELOAD_EN
    logic              reload;
`endif

    always #5 clk = ~clk;

    rv_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
`ifdef BOOT_RELOAD_EN
        ,
        .reload     (reload)
`endif
    );

    typedef logic [7:0] byte_q_t [$];
    typedef struct { int addr; logic [31:0] data; int at; } wr_t;
    typedef wr_t wr_q_t [$];
    typedef struct {
        string        name;
        logic [127:0] stream;   // first byte in the top octet
        int           len;
        int           gap_pct;
        bit           exp_done;
        bit           exp_err;
        int           n_wr;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    int    acc_cnt  = 0;   // bytes accepted so far
    wr_t   got_q[$];       // observed IMEM writes, tagged with acc_cnt

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (imem_we) got_q.push_back('{addr: int'(imem_addr), data: imem_wdata, at: acc_cnt});
        if (!reset && rx_valid && rx_ready) acc_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Frame-level reference: word count, payload words, modular byte sum.
    function automatic void model(input byte_q_t s, output bit d, output bit e, output wr_q_t w);
        int         n;
        logic [7:0] sum;
        w = {};
        d = 1'b0;
        e = 1'b0;
        n = int'(s[0]) + 256 * int'(s[1]);
        if (n > MAX_WORDS) begin
            e = 1'b1;
            return;
        end
        sum = s[0];
        sum += s[1];
        for (int k = 0; k < n; k++)
            w.push_back('{addr: k, data: {s[5+4*k], s[4+4*k], s[3+4*k], s[2+4*k]}, at: 2 + 4*(k+1)});
        for (int i = 2; i < 2 + 4*n; i++) sum += s[i];
        if (s[2+4*n] == sum) d = 1'b1;
        else                 e = 1'b1;
    endfunction

    task automatic do_reset(input bit check_vals);
        reset    = 1'b1;
        rx_valid = 1'b0;
`ifdef BOOT_RELOAD_EN
        reload   = 1'b0;
`endif
        #1;
        if (check_vals) begin
            check("rst/rx_ready",   32'(rx_ready),   32'd0);
            check("rst/imem_we",    32'(imem_we),    32'd0);
            check("rst/imem_addr",  32'(imem_addr),  32'd0);
            check("rst/imem_wdata", imem_wdata,      32'd0);
            check("rst/core_reset", 32'(core_reset), 32'd1);
            check("rst/done",       32'(done),       32'd0);
            check("rst/err",        32'(err),        32'd0);
        end
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t s, input int gap_pct, output bit ok);
        int i     = 0;
        int guard = 0;
        while (i < s.size() && guard < 4000) begin
            @(posedge clk);
            #2;
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = s[i];
            end
            @(negedge clk);
            if (rx_valid && rx_ready) i++;
            guard++;
        end
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        ok = (i == s.size());
    endtask

    task automatic run_image(input string tag, input byte_q_t s, input int gap_pct, input bit use_rst,
                             input bit exp_done, input bit exp_err, input wr_q_t exp_w);
        int base;
        int acc0;
        int n_got;
        bit ok;
        if (use_rst) do_reset(1'b0);
        base = got_q.size();
        acc0 = acc_cnt;
        send_bytes(s, gap_pct, ok);
        check({tag, "/all_bytes_taken"}, 32'(ok), 32'd1);
        // One cycle after the last accepted byte.
        @(negedge clk);
        check({tag, "/done"},       32'(done),       32'(exp_done));
        check({tag, "/err"},        32'(err),        32'(exp_err));
        check({tag, "/core_reset"}, 32'(core_reset), 32'(!exp_done));
        check({tag, "/rx_ready"},   32'(rx_ready),   32'd0);
        // Terminal state: further offered bytes are refused.
        repeat (3) begin
            @(posedge clk);
            #2;
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        @(negedge clk);
        check({tag, "/hold_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "/hold_done"},     32'(done),     32'(exp_done));
        check({tag, "/hold_err"},      32'(err),      32'(exp_err));
        check({tag, "/not_both"},      32'(done && err), 32'd0);
        n_got = got_q.size() - base;
        check({tag, "/n_writes"}, 32'(n_got), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < n_got; k++) begin
            check($sformatf("%s/w%0d_addr", tag, k), 32'(got_q[base+k].addr),      32'(exp_w[k].addr));
            check($sformatf("%s/w%0d_data", tag, k), got_q[base+k].data,           exp_w[k].data);
            check($sformatf("%s/w%0d_at",   tag, k), 32'(got_q[base+k].at - acc0), 32'(exp_w[k].at));
        end
    endtask

    vec_t    vecs[5];
    byte_q_t s;
    wr_q_t   ew;
    bit      ed, ee, ok;
    int      n;
    logic [7:0] sum;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`ifdef BOOT_RELOAD_EN
        reload   = 1'b0;
`endif

        vecs[0] = '{name: "good",    stream: {88'h02_00_93_00_50_00_13_01_10_00_09, 40'h0}, len: 11,
                    gap_pct: 0,  exp_done: 1, exp_err: 0, n_wr: 2, w0: 32'h00500093, w1: 32'h00100113};
        vecs[1] = '{name: "badsum",  stream: {88'h02_00_93_00_50_00_13_01_10_00_0A, 40'h0}, len: 11,
                    gap_pct: 0,  exp_done: 0, exp_err: 1, n_wr: 2, w0: 32'h00500093, w1: 32'h00100113};
        vecs[2] = '{name: "empty",   stream: {24'h00_00_00, 104'h0}, len: 3,
                    gap_pct: 0,  exp_done: 1, exp_err: 0, n_wr: 0, w0: 32'h0, w1: 32'h0};
        vecs[3] = '{name: "oversize", stream: {16'h01_01, 112'h0}, len: 2,
                    gap_pct: 0,  exp_done: 0, exp_err: 1, n_wr: 0, w0: 32'h0, w1: 32'h0};
        vecs[4] = '{name: "gaps",    stream: {88'h02_00_93_00_50_00_13_01_10_00_09, 40'h0}, len: 11,
                    gap_pct: 50, exp_done: 1, exp_err: 0, n_wr: 2, w0: 32'h00500093, w1: 32'h00100113};

        do_reset(1'b1);

        for (int v = 0; v < 5; v++) begin
            s  = {};
            ew = {};
            for (int i = 0; i < vecs[v].len; i++) s.push_back(vecs[v].stream[127-8*i -: 8]);
            for (int k = 0; k < vecs[v].n_wr; k++)
                ew.push_back('{addr: k, data: (k == 0) ? vecs[v].w0 : vecs[v].w1, at: 2 + 4*(k+1)});
            run_image(vecs[v].name, s, vecs[v].gap_pct, 1'b1, vecs[v].exp_done, vecs[v].exp_err, ew);
        end

        // Reset after five bytes of a good image: async return to reset values.
        do_reset(1'b0);
        s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
        send_bytes(s, 0, ok);
        check("midload/bytes_taken", 32'(ok), 32'd1);
        do_reset(1'b1);
        s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
        model(s, ed, ee, ew);
        run_image("replay", s, 0, 1'b0, ed, ee, ew);

        // Largest accepted image: every IMEM address is written once.
        s = {8'(MAX_WORDS), 8'(MAX_WORDS >> 8)};
        sum = s[0];
        sum += s[1];
        for (int i = 0; i < 4*MAX_WORDS; i++) begin
            s.push_back(8'($urandom));
            sum += s[s.size()-1];
        end
        s.push_back(sum);
        model(s, ed, ee, ew);
        run_image("max_words", s, 10, 1'b1, ed, ee, ew);

        // Randomized frames: lengths, payloads, checksum corruption, oversize, gaps.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 9) == 0) n = int'($urandom_range(MAX_WORDS + 1, 65535));
            else                           n = int'($urandom_range(0, 6));
            s = {8'(n), 8'(n >> 8)};
            if (n <= MAX_WORDS) begin
                sum = s[0];
                sum += s[1];
                for (int i = 0; i < 4*n; i++) begin
                    s.push_back(8'($urandom));
                    sum += s[s.size()-1];
                end
                if ($urandom_range(0, 3) == 0) sum += 8'($urandom_range(1, 255));
                s.push_back(sum);
            end
            model(s, ed, ee, ew);
            run_image($sformatf("rand%0d", r), s, int'($urandom_range(0, 60)), 1'b1, ed, ee, ew);
        end

`ifdef BOOT_RELOAD_EN
        s = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h09};
        model(s, ed, ee, ew);
        run_image("pre_reload", s, 0, 1'b1, ed, ee, ew);
        @(posedge clk); #2; reload = 1'b1;
        @(posedge clk); #2; reload = 1'b0;
        @(negedge clk);
        check("reload/core_reset", 32'(core_reset), 32'd1);
        check("reload/done",       32'(done),       32'd0);
        check("reload/rx_ready",   32'(rx_ready),   32'd1);
        // Checksum byte: 01+00+EF+BE+AD+DE mod 256 = 39.
        s  = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39};
        ew = {'{addr: 0, data: 32'hDEADBEEF, at: 6}};
        run_image("second_image", s, 0, 1'b0, 1'b1, 1'b0, ew);
        // Reload also leaves ERROR.
        s  = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3A};
        run_image("reload_err", s, 0, 1'b1, 1'b0, 1'b1, ew);
        @(posedge clk); #2; reload = 1'b1;
        @(posedge clk); #2; reload = 1'b0;
        @(negedge clk);
        check("reload_err/err",        32'(err),        32'd0);
        check("reload_err/core_reset", 32'(core_reset), 32'd1);
        check("reload_err/rx_ready",   32'(rx_ready),   32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
